// File: rtl/counter_share_ctrl_if.sv
// Bus between the requester blocks and the shared-counter controller.
// The requester side drives req/dur/en; the controller drives the rest.
interface counter_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int CW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] dur;
  logic               en;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [CW-1:0]      count;
  logic [NREQ-1:0]    done;

  modport master (output req, dur, en, input grant, busy, count, done);
  modport slave  (input req, dur, en, output grant, busy, count, done);
endinterface

// File: rtl/counter_share_ctrl.sv
// Time-shares one CW-bit up-counter between NREQ requesters.
// Round-robin pick in IDLE, count in RUN under the global enable,
// one-cycle done pulse in DONE. Every output is a register.
module counter_share_ctrl #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input logic                 clk,
  input logic                 reset,
  counter_share_ctrl_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [IW-1:0]             r_owner, w_owner_nxt;
  logic [IW-1:0]             r_ptr, w_ptr_nxt;
  logic [IW-1:0]             w_win, w_cand, w_owner_inc;
  logic                      w_found;
  logic [CW-1:0]             r_dur, w_dur_nxt;
  logic [CW-1:0]             r_count, w_count_nxt;
  logic [NREQ-1:0]           r_grant, w_grant_nxt;
  logic [NREQ-1:0]           r_done, w_done_nxt;
  logic                      r_busy;
  logic                      w_own_req, w_at_end;
  logic [NREQ-1:0][CW-1:0]   w_dur_arr;

  // (a + b) mod NREQ, works for non-power-of-two NREQ too
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    return IW'((int'(a) + b) % NREQ);
  endfunction

  assign w_dur_arr   = bus.dur;
  assign w_own_req   = bus.req[r_owner];
  assign w_at_end    = (r_count == r_dur);
  assign w_owner_inc = wrap_add(r_owner, 1);

  // Round-robin search: first requester at or after the pointer
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = r_ptr;
    for (int j = 0; j < NREQ; j++) begin
      w_cand = wrap_add(r_ptr, j);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // State register plus all registered outputs and bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_dur   <= '0;
      r_count <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_dur   <= w_dur_nxt;
      r_count <= w_count_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state: withdrawal beats completion, completion beats counting
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!w_own_req)    w_state_nxt = S_IDLE;
        else if (w_at_end) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, latched duration and pointer
  always_comb begin
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_dur_nxt   = r_dur;
    w_count_nxt = r_count;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        w_count_nxt = '0;
        if (w_found) begin
          w_owner_nxt        = w_win;
          w_dur_nxt          = w_dur_arr[w_win];
          w_grant_nxt[w_win] = 1'b1;
        end
      end
      S_RUN: begin
        if (!w_own_req) begin
          // aborted interval: release without a done pulse
          w_grant_nxt = '0;
          w_count_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
        end else if (w_at_end) begin
          w_done_nxt[r_owner] = 1'b1;
          w_ptr_nxt           = w_owner_inc;
        end else if (bus.en) begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      S_DONE: begin
        w_grant_nxt = '0;
        w_count_nxt = '0;
      end
      default: begin
        w_grant_nxt = '0;
        w_count_nxt = '0;
      end
    endcase
  end

  assign bus.grant = r_grant;
  assign bus.busy  = r_busy;
  assign bus.count = r_count;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_counter_share_ctrl.sv
// Bench for counter_share_ctrl: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against an interval model.
module tb_counter_share_ctrl;
  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  counter_share_ctrl_if #(.NREQ(NREQ), .CW(CW)) bus();

  counter_share_ctrl #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- interval model ----------------
  // owner < 0 means nobody holds the counter; fin marks the completion cycle.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_dur   = 0;
  int m_ptr   = 0;
  bit m_fin   = 0;
  bit m_live  = 0;

  always @(posedge clk) begin
    m_live = 1;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_dur = 0; m_ptr = 0; m_fin = 0;
    end else if (m_owner < 0) begin
      for (int j = 0; j < NREQ; j++)
        if (m_owner < 0 && bus.req[(m_ptr + j) % NREQ]) m_owner = (m_ptr + j) % NREQ;
      if (m_owner >= 0) begin
        m_dur = int'(bus.dur[m_owner*CW +: CW]);
        m_cnt = 0;
      end
    end else if (m_fin) begin
      m_owner = -1; m_fin = 0; m_cnt = 0;
    end else if (!bus.req[m_owner]) begin
      m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_cnt = 0;
    end else if (m_cnt == m_dur) begin
      m_fin = 1; m_ptr = (m_owner + 1) % NREQ;
    end else if (bus.en) begin
      m_cnt++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int eg, ed;
    if (m_live) begin
      eg = (m_owner >= 0) ? (1 << m_owner) : 0;
      ed = (m_owner >= 0 && m_fin) ? (1 << m_owner) : 0;
      chk("m_grant", int'(bus.grant), eg);
      chk("m_done",  int'(bus.done),  ed);
      chk("m_busy",  int'(bus.busy),  (m_owner >= 0) ? 1 : 0);
      chk("m_count", int'(bus.count), m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_dur(input int i, input int v);
    bus.dur[i*CW +: CW] = CW'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  int rr_q[$];
  int exp_rr[5] = '{1, 2, 4, 8, 1};
  int prev_g;

  initial begin
    bus.req = 4'b1111; bus.dur = '0; bus.en = 1'b1;
    for (int i = 0; i < NREQ; i++) set_dur(i, 1);

    // reset held with every requester asking
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_grant", int'(bus.grant), 0);
      chk("rst_done",  int'(bus.done),  0);
      chk("rst_count", int'(bus.count), 0);
      chk("rst_busy",  int'(bus.busy),  0);
    end
    rst = 1'b0;
    tick();
    chk("first_grant", int'(bus.grant), 1);

    // round-robin order with req=1111, dur=1 (continues from the first grant)
    prev_g = 0;
    for (int c = 0; c < 22; c++) begin
      if (bus.grant != 0 && prev_g == 0) rr_q.push_back(int'(bus.grant));
      prev_g = int'(bus.grant);
      tick();
    end
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < rr_q.size()) ? rr_q[i] : -1, exp_rr[i]);

    // single request, dur=3
    do_reset();
    set_dur(2, 3); bus.req = 4'b0100;
    tick(); chk("single_grant", int'(bus.grant), 4);
            chk("single_cnt0", int'(bus.count), 0);
    tick(); tick(); tick();
    chk("single_cnt3", int'(bus.count), 3);
    chk("single_nodone", int'(bus.done), 0);
    tick(); chk("single_done", int'(bus.done), 4);
            chk("single_hold", int'(bus.count), 3);
    bus.req = '0;
    tick(); chk("single_rel", int'(bus.grant), 0);
            chk("single_idle", int'(bus.busy), 0);

    // pause: en low for 3 cycles at count=2
    do_reset();
    set_dur(0, 5); bus.req = 4'b0001;
    tick(); tick(); tick();
    chk("pause_at2", int'(bus.count), 2);
    bus.en = 1'b0;
    tick(); tick(); tick();
    chk("pause_hold", int'(bus.count), 2);
    bus.en = 1'b1;
    tick(); tick(); tick();
    chk("pause_cnt5", int'(bus.count), 5);
    chk("pause_nodone", int'(bus.done), 0);
    tick(); chk("pause_done", int'(bus.done), 1);
    bus.req = '0; tick();

    // withdrawal at count=2, next winner is index 2
    do_reset();
    for (int i = 0; i < NREQ; i++) set_dur(i, 5);
    bus.req = 4'b0010;
    tick(); chk("wd_grant", int'(bus.grant), 2);
    tick(); tick(); chk("wd_cnt2", int'(bus.count), 2);
    bus.req = 4'b0101;
    tick(); chk("wd_rel", int'(bus.grant), 0);
            chk("wd_nodone", int'(bus.done), 0);
            chk("wd_cnt0", int'(bus.count), 0);
    tick(); chk("wd_next", int'(bus.grant), 4);
    // reset mid-RUN
    tick(); tick();
    rst = 1'b1;
    tick(); chk("rab_grant", int'(bus.grant), 0);
            chk("rab_busy", int'(bus.busy), 0);
            chk("rab_done", int'(bus.done), 0);
    rst = 1'b0; bus.req = '0; tick();

    // dur=0: done one cycle after grant
    do_reset();
    set_dur(3, 0); bus.req = 4'b1000;
    tick(); chk("d0_grant", int'(bus.grant), 8);
    tick(); chk("d0_done", int'(bus.done), 8);
    bus.req = '0; tick();

    // dur=15: full range, no wrap
    do_reset();
    set_dur(0, 15); bus.req = 4'b0001;
    tick();
    repeat (15) tick();
    chk("d15_cnt", int'(bus.count), 15);
    tick(); chk("d15_done", int'(bus.done), 1);
            chk("d15_hold", int'(bus.count), 15);
    bus.req = '0; tick();

    // dur change after grant is ignored
    do_reset();
    set_dur(0, 2); bus.req = 4'b0001;
    tick(); set_dur(0, 7);
    tick(); tick(); chk("dchg_cnt", int'(bus.count), 2);
    tick(); chk("dchg_done", int'(bus.done), 1);
    bus.req = '0; tick();

    // randomized traffic, model-checked every cycle
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) set_dur(i, int'($urandom_range(0, 15)));
      bus.en = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
